// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: recovers the four digits shown on a multiplexed 7-segment
// display by watching its active-low anode and segment drive lines.
module seg_scan_decoder #(
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  AN,
    input  logic [7:0]  SEG,
    output logic [15:0] num,
    output logic [3:0]  dp,
    output logic [3:0]  blank,
    output logic        frame_valid,
    output logic        glyph_err,
    output logic        stale
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_HELD   = 2'd2;

    localparam int              TO_W       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_MAX     = TO_W'(TIMEOUT_CYCLES);
    localparam logic [7:0]      STABLE_MAX = 8'(STABLE_CYCLES);

    // Returned as {err, blank, code[3:0]}; input is active-high gfedcba.
    function automatic logic [5:0] decode_glyph(input logic [6:0] segs);
        logic [5:0] r;
        case (segs)
            7'h3F:   r = 6'h00;
            7'h06:   r = 6'h01;
            7'h5B:   r = 6'h02;
            7'h4F:   r = 6'h03;
            7'h66:   r = 6'h04;
            7'h6D:   r = 6'h05;
            7'h7D:   r = 6'h06;
            7'h07:   r = 6'h07;
            7'h7F:   r = 6'h08;
            7'h6F:   r = 6'h09;
            7'h77:   r = 6'h0A;
            7'h7C:   r = 6'h0B;
            7'h39:   r = 6'h0C;
            7'h5E:   r = 6'h0D;
            7'h79:   r = 6'h0E;
            7'h71:   r = 6'h0F;
            7'h00:   r = 6'b01_0000;
            default: r = 6'b10_0000;
        endcase
        return r;
    endfunction

    function automatic logic is_one_hot_low(input logic [3:0] an);
        logic [3:0] act;
        act = ~an;
        return (act != 4'h0) && ((act & (act - 4'd1)) == 4'h0);
    endfunction

    function automatic logic [1:0] digit_index(input logic [3:0] an);
        logic [1:0] idx;
        case (an)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            default: idx = 2'd3;
        endcase
        return idx;
    endfunction

    logic [3:0]       an_q, an_d;
    logic [7:0]       seg_q, seg_d;
    logic [1:0]       state_q, state_d;
    logic [7:0]       count_q, count_d;
    logic [3:0]       cmp_an_q, cmp_an_d;
    logic [7:0]       cmp_seg_q, cmp_seg_d;
    logic [3:0][3:0]  sh_code_q, sh_code_d;
    logic [3:0]       sh_dp_q, sh_dp_d;
    logic [3:0]       sh_blank_q, sh_blank_d;
    logic [3:0]       sh_err_q, sh_err_d;
    logic [3:0]       seen_q, seen_d;
    logic [3:0][3:0]  num_q, num_d;
    logic [3:0]       dp_q, dp_d;
    logic [3:0]       blank_q, blank_d;
    logic             fv_q, fv_d;
    logic             gerr_q, gerr_d;
    logic [TO_W-1:0]  to_q, to_d;

    logic             sample_same;
    logic             sample_onehot;
    logic [7:0]       count_inc;
    logic             capture;
    logic             restart;
    logic             frame_done;
    logic [1:0]       cap_idx;
    logic [5:0]       cap_info;

    always_comb begin
        an_d  = AN;
        seg_d = SEG;
    end

    assign sample_same   = (an_q == cmp_an_q) && (seg_q == cmp_seg_q);
    assign sample_onehot = is_one_hot_low(an_q);
    assign count_inc     = count_q + 8'd1;

    // A change of sample in any state falls back to the IDLE entry decision.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        cmp_an_d  = cmp_an_q;
        cmp_seg_d = cmp_seg_q;
        capture   = 1'b0;
        restart   = 1'b0;
        case (state_q)
            ST_SETTLE: begin
                if (sample_same) begin
                    count_d = count_inc;
                    if (count_inc == STABLE_MAX) begin
                        capture = 1'b1;
                        state_d = ST_HELD;
                    end
                end else begin
                    restart = 1'b1;
                end
            end
            ST_HELD: begin
                if (!sample_same) begin
                    restart = 1'b1;
                end
            end
            default: restart = 1'b1;
        endcase
        if (restart) begin
            if (sample_onehot) begin
                cmp_an_d  = an_q;
                cmp_seg_d = seg_q;
                count_d   = 8'd1;
                state_d   = ST_SETTLE;
            end else begin
                count_d   = 8'd0;
                state_d   = ST_IDLE;
            end
        end
    end

    // On capture the compare register equals the sample, so decode from it.
    assign cap_idx    = digit_index(cmp_an_q);
    assign cap_info   = decode_glyph(~cmp_seg_q[6:0]);
    assign frame_done = (seen_q == 4'hF);

    always_comb begin
        sh_code_d  = sh_code_q;
        sh_dp_d    = sh_dp_q;
        sh_blank_d = sh_blank_q;
        sh_err_d   = sh_err_q;
        seen_d     = frame_done ? 4'h0 : seen_q;
        if (capture) begin
            sh_code_d[cap_idx]  = cap_info[3:0];
            sh_blank_d[cap_idx] = cap_info[4];
            sh_err_d[cap_idx]   = cap_info[5];
            sh_dp_d[cap_idx]    = ~cmp_seg_q[7];
            seen_d[cap_idx]     = 1'b1;
        end
    end

    // Published frame copies the shadow as it stood before this cycle's capture.
    always_comb begin
        num_d   = num_q;
        dp_d    = dp_q;
        blank_d = blank_q;
        gerr_d  = gerr_q;
        fv_d    = frame_done;
        if (frame_done) begin
            num_d   = sh_code_q;
            dp_d    = sh_dp_q;
            blank_d = sh_blank_q;
            gerr_d  = |sh_err_q;
        end
    end

    always_comb begin
        to_d = to_q;
        if (capture) begin
            to_d = '0;
        end else if (to_q != TO_MAX) begin
            to_d = to_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            an_q       <= 4'hF;
            seg_q      <= 8'hFF;
            state_q    <= ST_IDLE;
            count_q    <= 8'd0;
            cmp_an_q   <= 4'h0;
            cmp_seg_q  <= 8'h00;
            sh_code_q  <= '0;
            sh_dp_q    <= 4'h0;
            sh_blank_q <= 4'h0;
            sh_err_q   <= 4'h0;
            seen_q     <= 4'h0;
            num_q      <= '0;
            dp_q       <= 4'h0;
            blank_q    <= 4'h0;
            fv_q       <= 1'b0;
            gerr_q     <= 1'b0;
            to_q       <= '0;
        end else begin
            an_q       <= an_d;
            seg_q      <= seg_d;
            state_q    <= state_d;
            count_q    <= count_d;
            cmp_an_q   <= cmp_an_d;
            cmp_seg_q  <= cmp_seg_d;
            sh_code_q  <= sh_code_d;
            sh_dp_q    <= sh_dp_d;
            sh_blank_q <= sh_blank_d;
            sh_err_q   <= sh_err_d;
            seen_q     <= seen_d;
            num_q      <= num_d;
            dp_q       <= dp_d;
            blank_q    <= blank_d;
            fv_q       <= fv_d;
            gerr_q     <= gerr_d;
            to_q       <= to_d;
        end
    end

    assign num         = num_q;
    assign dp          = dp_q;
    assign blank       = blank_q;
    assign frame_valid = fv_q;
    assign glyph_err   = gerr_q;
    assign stale       = (to_q == TO_MAX);

endmodule
